csr_machine_file: RTL and testbench
===================================

Name: csr_machine_file

Overview:
Machine-mode control/status register file for the RV32I core, parametrised in XLEN. Sits beside the execute/write-back stages. Provides:
- registered CSR reads with legality query;
- atomic write/set/clear updates;
- 64-bit cycle and instret counters;
- trap entry and mret state updates;
- interrupt pending and trap vector generation for the fetch unit.

Parameters:
C_XLEN, 32, data width; 32 or 64 (64: counter high-half addresses are illegal).
C_HART_ID, 0, value returned by mhartid.
C_RESET_MTVEC, 32'h0000_0100, mtvec reset value (mode bits included).

Ports:
clk_i  in  1  clock
resetb_i  in  1  asynchronous active-low reset
clk_en_i  in  1  global clock enable; all state holds when low
rd_i  in  1  read strobe
rd_addr_i  in  12  read/query address
rd_data_o  out  C_XLEN  registered read data
rd_illegal_rd_o  out  1  registered: rd_addr_i not implemented
rd_illegal_wr_o  out  1  registered: rd_addr_i not writable
wr_i  in  1  write strobe
wr_mode_i  in  2  01 write, 10 set, 11 clear, 00 none
wr_addr_i  in  12  write address
wr_data_i  in  C_XLEN  write operand
trap_i  in  1  trap entry this cycle
trap_cause_i  in  C_XLEN  mcause value (MSB = interrupt)
trap_pc_i  in  C_XLEN  faulting/interrupted PC
trap_tval_i  in  C_XLEN  mtval value
mret_i  in  1  mret retiring this cycle
instret_i  in  1  instruction retired this cycle
irq_ext_i, irq_timer_i, irq_sw_i  in  1 each  level interrupt sources
irq_pending_o  out  1  enabled interrupt pending
trap_vector_o  out  C_XLEN  trap target PC
mepc_o  out  C_XLEN  mepc for mret
hpl_o  out  2  current privilege, constant 2'b11

Behaviour:
- Reset: resetb_i is asynchronous, active-low; clock is clk_i. On reset:
  - mstatus: MIE=0, MPIE=0, MPP=11;
  - mie, mscratch, mepc, mcause, mtval, counters = 0;
  - mtvec = C_RESET_MTVEC;
  - mip sample flops = 0;
  - rd_data_o = 0, rd_illegal_rd_o = 0, rd_illegal_wr_o = 0.
- Address map:
  - mstatus 300, misa 301, mie 304, mtvec 305;
  - mscratch 340, mepc 341, mcause 342, mtval 343, mip 344;
  - mcycle B00, minstret B02, mcycleh B80, minstreth B82;
  - cycle C00, instret C02, cycleh C80, instreth C82;
  - mvendorid F11, marchid F12, mimpid F13 (all read 0), mhartid F14.
  - Any other address is unimplemented.
- Reads:
  - When clk_en_i, one-cycle latency.
  - rd_data_o updates only when rd_i.
  - Illegal flags update every enabled cycle from rd_addr_i:
    - illegal_rd = unimplemented;
    - illegal_wr = unimplemented OR addr[11:10]==11.
- Writes: applied at the enabled clock edge when wr_i and wr_mode_i!=00.
  - New value: write = d; set = old|d; clear = old&~d.
  - Writes to illegal_wr addresses are dropped.
  - WARL fields:
    - mstatus: only MIE(3) and MPIE(7) writable; MPP reads 11.
    - mepc: bits[1:0] forced 0.
    - mtvec: mode values other than 0 and 1 store as 0.
    - mie: only bits 3, 7, 11 writable.
    - mip: read-only, so writes are illegal (illegal_wr asserted at 344).
- Counters:
  - mcycle increments every enabled cycle; minstret increments when instret_i.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to either half takes priority over that cycle's increment; the other half holds.
- mip: bits 11/7/3 are flops sampling irq_ext_i/irq_timer_i/irq_sw_i each enabled cycle.
- irq_pending_o: combinational, = mstatus.MIE & |(mip & mie).
- Trap (trap_i):
  - mepc <= trap_pc_i with bits[1:0]=0;
  - mcause <= trap_cause_i; mtval <= trap_tval_i;
  - MPIE <= MIE; MIE <= 0.
- mret (mret_i): MIE <= MPIE; MPIE <= 1.
- Priority: trap > mret > CSR write for the same cycle; the losing CSR write is dropped entirely.
- trap_vector_o (combinational, uses registered mcause/mtvec):
  - default = {mtvec[XLEN-1:2], 2'b00};
  - if mtvec mode=1 and mcause MSB=1, add 4*mcause[4:0].
- mepc_o is the registered mepc.
- clk_en_i low: no state change, no counter increment, outputs hold.

Decomposition:
- Shared package csr_defs:
  - 12-bit CSR address constants;
  - wr_mode encodings;
  - mstatus/mip/mie bit positions;
  - mcause interrupt codes (3, 7, 11).
- One sub-module, csr_counter64:
  - 64-bit counter with increment enable;
  - low/high/full write ports (XLEN-sized);
  - instantiated twice (cycle, instret).

Test Plan:
- Reset then read F14 with C_HART_ID=5 -> next cycle rd_data_o=5, illegal_rd=0, illegal_wr=1.
- Write 305 = 0000_0201 (mode 1), then trap_i with cause 8000_0007 -> trap_vector_o=0000_021C, MIE=0, MPIE=old MIE.
- Set 300 with 0000_0008, then mret_i -> mstatus reads 0000_1880 (MPP=11, MPIE=1, MIE=0 after MPIE→MIE copy of 0).
- Write B00 = FFFF_FFFF, B80 = 0, run two enabled cycles -> mcycleh=1, mcycle=1; same-cycle write beats increment.
- mie=0000_0080, MIE=1, pulse irq_timer_i -> irq_pending_o high one cycle after sample, low when clk_en_i held low doesn't resample.
- Simultaneous trap_i and wr_i to 340 with 1234_5678 -> mscratch unchanged, mepc=trap_pc_i&~3; read 7C0 -> illegal_rd=1, illegal_wr=1.

Source files
------------

// File: rtl/csr_defs.sv
// Shared definitions for the machine-mode CSR file: addresses, update modes,
// status/interrupt bit positions and address decode helpers.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    WR_NONE  = 2'b00,
    WR_WRITE = 2'b01,
    WR_SET   = 2'b10,
    WR_CLEAR = 2'b11
  } wr_mode_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Interrupt cause codes double as the mip/mie bit positions.
  localparam int IRQ_CODE_SW    = 3;
  localparam int IRQ_CODE_TIMER = 7;
  localparam int IRQ_CODE_EXT   = 11;

  function automatic logic csr_implemented(input logic [11:0] addr, input logic xlen64);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
      CSR_MCYCLE, CSR_MINSTRET, CSR_CYCLE, CSR_INSTRET,
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH, CSR_CYCLEH, CSR_INSTRETH: return !xlen64;
      default: return 1'b0;
    endcase
  endfunction

  // The 0xC00-0xFFF block is read-only; mip is sampled from pins only.
  function automatic logic csr_writable(input logic [11:0] addr, input logic xlen64);
    return csr_implemented(addr, xlen64) && (addr[11:10] != 2'b11) && (addr != CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with CSR write ports; a write to either half
// beats the increment of the same cycle and leaves the other half untouched.
module csr_counter64
  import csr_defs::*;
#(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              i_en,
  input  logic              i_inc,
  input  logic              i_wr_lo,
  input  logic              i_wr_hi,
  input  logic [C_XLEN-1:0] i_wr_data,
  output logic [63:0]       o_count
);

  logic [63:0] r_count;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_wr_lo || i_wr_hi) begin
        // At XLEN=64 the low port covers the whole counter.
        if (i_wr_lo) r_count[C_XLEN-1:0] <= i_wr_data;
        if (i_wr_hi) r_count[63:32]      <= i_wr_data[31:0];
      end else if (i_inc) begin
        r_count <= r_count + 64'd1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file: registered reads, write/set/clear updates, counters,
// trap/mret bookkeeping, interrupt pending and trap vector generation.
module csr_machine_file
  import csr_defs::*;
#(
  parameter int                C_XLEN        = 32,
  parameter int                C_HART_ID     = 0,
  parameter logic [C_XLEN-1:0] C_RESET_MTVEC = C_XLEN'(32'h0000_0100)
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              rd_i,
  input  logic [11:0]       rd_addr_i,
  output logic [C_XLEN-1:0] rd_data_o,
  output logic              rd_illegal_rd_o,
  output logic              rd_illegal_wr_o,
  input  logic              wr_i,
  input  logic [1:0]        wr_mode_i,
  input  logic [11:0]       wr_addr_i,
  input  logic [C_XLEN-1:0] wr_data_i,
  input  logic              trap_i,
  input  logic [C_XLEN-1:0] trap_cause_i,
  input  logic [C_XLEN-1:0] trap_pc_i,
  input  logic [C_XLEN-1:0] trap_tval_i,
  input  logic              mret_i,
  input  logic              instret_i,
  input  logic              irq_ext_i,
  input  logic              irq_timer_i,
  input  logic              irq_sw_i,
  output logic              irq_pending_o,
  output logic [C_XLEN-1:0] trap_vector_o,
  output logic [C_XLEN-1:0] mepc_o,
  output logic [1:0]        hpl_o
);

  localparam logic LP_XLEN64 = (C_XLEN == 64);
  localparam logic [C_XLEN-1:0] LP_IRQ_MASK =
    C_XLEN'((1 << IRQ_CODE_EXT) | (1 << IRQ_CODE_TIMER) | (1 << IRQ_CODE_SW));

  logic              r_mstatus_mie, r_mstatus_mpie;
  logic [C_XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic              r_irq_ext, r_irq_timer, r_irq_sw;
  logic [C_XLEN-1:0] r_rd_data;
  logic              r_ill_rd, r_ill_wr;

  logic [63:0]       w_cycle, w_instret;
  logic [C_XLEN-1:0] w_mstatus, w_misa, w_mip;
  logic [C_XLEN-1:0] w_rd_value, w_wr_old, w_wr_new, w_trap_vector;
  logic              w_wr_fire;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
    w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
    w_mip = '0;
    w_mip[IRQ_CODE_EXT]   = r_irq_ext;
    w_mip[IRQ_CODE_TIMER] = r_irq_timer;
    w_mip[IRQ_CODE_SW]    = r_irq_sw;
    w_misa = '0;
    w_misa[C_XLEN-1:C_XLEN-2] = LP_XLEN64 ? 2'b10 : 2'b01;
    w_misa[8] = 1'b1;
  end

  function automatic logic [C_XLEN-1:0] csr_read(input logic [11:0] addr);
    logic [C_XLEN-1:0] v;
    v = '0;
    if (csr_implemented(addr, LP_XLEN64)) begin
      case (addr)
        CSR_MSTATUS:                  v = w_mstatus;
        CSR_MISA:                     v = w_misa;
        CSR_MIE:                      v = r_mie;
        CSR_MTVEC:                    v = r_mtvec;
        CSR_MSCRATCH:                 v = r_mscratch;
        CSR_MEPC:                     v = r_mepc;
        CSR_MCAUSE:                   v = r_mcause;
        CSR_MTVAL:                    v = r_mtval;
        CSR_MIP:                      v = w_mip;
        CSR_MCYCLE, CSR_CYCLE:        v = C_XLEN'(w_cycle);
        CSR_MCYCLEH, CSR_CYCLEH:      v = C_XLEN'(w_cycle[63:32]);
        CSR_MINSTRET, CSR_INSTRET:    v = C_XLEN'(w_instret);
        CSR_MINSTRETH, CSR_INSTRETH:  v = C_XLEN'(w_instret[63:32]);
        CSR_MHARTID:                  v = C_XLEN'(C_HART_ID);
        default:                      v = '0;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    w_rd_value = csr_read(rd_addr_i);
    w_wr_old   = csr_read(wr_addr_i);
    w_wr_new   = w_wr_old;
    case (wr_mode_e'(wr_mode_i))
      WR_WRITE: w_wr_new = wr_data_i;
      WR_SET:   w_wr_new = w_wr_old | wr_data_i;
      WR_CLEAR: w_wr_new = w_wr_old & ~wr_data_i;
      default:  w_wr_new = w_wr_old;
    endcase
  end

  // Trap and mret win over a CSR write in the same cycle; the write is lost.
  assign w_wr_fire = clk_en_i && wr_i && (wr_mode_i != WR_NONE) &&
                     csr_writable(wr_addr_i, LP_XLEN64) && !trap_i && !mret_i;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= C_RESET_MTVEC;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_irq_ext      <= 1'b0;
      r_irq_timer    <= 1'b0;
      r_irq_sw       <= 1'b0;
      r_rd_data      <= '0;
      r_ill_rd       <= 1'b0;
      r_ill_wr       <= 1'b0;
    end else if (clk_en_i) begin
      r_ill_rd    <= !csr_implemented(rd_addr_i, LP_XLEN64);
      r_ill_wr    <= !csr_writable(rd_addr_i, LP_XLEN64);
      if (rd_i) r_rd_data <= w_rd_value;
      r_irq_ext   <= irq_ext_i;
      r_irq_timer <= irq_timer_i;
      r_irq_sw    <= irq_sw_i;

      if (trap_i) begin
        r_mepc         <= {trap_pc_i[C_XLEN-1:2], 2'b00};
        r_mcause       <= trap_cause_i;
        r_mtval        <= trap_tval_i;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_fire) begin
        case (wr_addr_i)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wr_new[MSTATUS_MIE];
            r_mstatus_mpie <= w_wr_new[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_wr_new & LP_IRQ_MASK;
          // Reserved vector modes collapse to direct mode.
          CSR_MTVEC:    r_mtvec    <= {w_wr_new[C_XLEN-1:2],
                                       (w_wr_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
          CSR_MSCRATCH: r_mscratch <= w_wr_new;
          CSR_MEPC:     r_mepc     <= {w_wr_new[C_XLEN-1:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wr_new;
          CSR_MTVAL:    r_mtval    <= w_wr_new;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 #(.C_XLEN(C_XLEN)) u_cycle (
    .clk_i     (clk_i),
    .resetb_i  (resetb_i),
    .i_en      (clk_en_i),
    .i_inc     (1'b1),
    .i_wr_lo   (w_wr_fire && (wr_addr_i == CSR_MCYCLE)),
    .i_wr_hi   (w_wr_fire && (wr_addr_i == CSR_MCYCLEH)),
    .i_wr_data (w_wr_new),
    .o_count   (w_cycle)
  );

  csr_counter64 #(.C_XLEN(C_XLEN)) u_instret (
    .clk_i     (clk_i),
    .resetb_i  (resetb_i),
    .i_en      (clk_en_i),
    .i_inc     (instret_i),
    .i_wr_lo   (w_wr_fire && (wr_addr_i == CSR_MINSTRET)),
    .i_wr_hi   (w_wr_fire && (wr_addr_i == CSR_MINSTRETH)),
    .i_wr_data (w_wr_new),
    .o_count   (w_instret)
  );

  // Vectored mode offsets only interrupts, by four bytes per cause code.
  always_comb begin
    w_trap_vector = {r_mtvec[C_XLEN-1:2], 2'b00};
    if ((r_mtvec[1:0] == 2'b01) && r_mcause[C_XLEN-1])
      w_trap_vector = w_trap_vector + C_XLEN'({r_mcause[4:0], 2'b00});
  end

  assign irq_pending_o   = r_mstatus_mie & |(w_mip & r_mie);
  assign trap_vector_o   = w_trap_vector;
  assign mepc_o          = r_mepc;
  assign hpl_o           = 2'b11;
  assign rd_data_o       = r_rd_data;
  assign rd_illegal_rd_o = r_ill_rd;
  assign rd_illegal_wr_o = r_ill_wr;

endmodule

// File: tb/tb_csr_machine_file.sv
// Self-checking bench for csr_machine_file: decode table, directed corner
// sequences and randomized traffic against an architectural reference model.
module tb_csr_machine_file;

  logic        clk_i = 1'b0;
  logic        resetb_i;
  logic        clk_en_i, rd_i, wr_i, trap_i, mret_i, instret_i;
  logic        irq_ext_i, irq_timer_i, irq_sw_i;
  logic [11:0] rd_addr_i, wr_addr_i;
  logic [1:0]  wr_mode_i;
  logic [31:0] wr_data_i, trap_cause_i, trap_pc_i, trap_tval_i;
  logic [31:0] rd_data_o, trap_vector_o, mepc_o;
  logic        rd_illegal_rd_o, rd_illegal_wr_o, irq_pending_o;
  logic [1:0]  hpl_o;

  always #5 clk_i = ~clk_i;

  csr_machine_file #(
    .C_XLEN(32), .C_HART_ID(5), .C_RESET_MTVEC(32'h0000_0100)
  ) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .rd_i(rd_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_illegal_rd_o(rd_illegal_rd_o), .rd_illegal_wr_o(rd_illegal_wr_o),
    .wr_i(wr_i), .wr_mode_i(wr_mode_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .instret_i(instret_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
    .irq_pending_o(irq_pending_o), .trap_vector_o(trap_vector_o),
    .mepc_o(mepc_o), .hpl_o(hpl_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural reference model ----------------
  bit          m_mie_b, m_mpie, m_ext, m_tim, m_sw, m_ill_rd, m_ill_wr;
  logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rd;
  logic [63:0] m_cycle, m_instret;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_writable(input logic [11:0] a);
    return m_impl(a) && a[11:10] != 2'b11 && a != 12'h344;
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(m_ext) << 11) | (32'(m_tim) << 7) | (32'(m_sw) << 3);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_r;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF14: return 32'd5;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_irq();
    return m_mie_b && ((m_mip() & m_mie_r) != 32'd0);
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] base;
    base = m_mtvec & ~32'd3;
    if (m_mtvec[1:0] == 2'b01 && m_mcause[31]) base = base + 32'd4 * m_mcause[4:0];
    return base;
  endfunction

  task automatic model_reset();
    m_mie_b = 0; m_mpie = 0; m_ext = 0; m_tim = 0; m_sw = 0;
    m_ill_rd = 0; m_ill_wr = 0; m_rd = '0;
    m_mie_r = '0; m_mtvec = 32'h100; m_mscratch = '0; m_mepc = '0;
    m_mcause = '0; m_mtval = '0; m_cycle = '0; m_instret = '0;
  endtask

  // One enabled clock edge of architectural behaviour, from current inputs.
  task automatic model_step();
    logic [31:0] old_v, new_v;
    logic [63:0] cyc0, ins0;
    bit          fire;
    if (!clk_en_i) return;
    if (rd_i) m_rd = m_read(rd_addr_i);
    m_ill_rd = !m_impl(rd_addr_i);
    m_ill_wr = !m_writable(rd_addr_i);
    old_v = m_read(wr_addr_i);
    case (wr_mode_i)
      2'b01:   new_v = wr_data_i;
      2'b10:   new_v = old_v | wr_data_i;
      2'b11:   new_v = old_v & ~wr_data_i;
      default: new_v = old_v;
    endcase
    fire = wr_i && wr_mode_i != 2'b00 && m_writable(wr_addr_i) && !trap_i && !mret_i;
    cyc0 = m_cycle;
    ins0 = m_instret;
    m_cycle = cyc0 + 64'd1;
    if (instret_i) m_instret = ins0 + 64'd1;
    if (fire && wr_addr_i == 12'hB00) m_cycle   = {cyc0[63:32], new_v};
    if (fire && wr_addr_i == 12'hB80) m_cycle   = {new_v, cyc0[31:0]};
    if (fire && wr_addr_i == 12'hB02) m_instret = {ins0[63:32], new_v};
    if (fire && wr_addr_i == 12'hB82) m_instret = {new_v, ins0[31:0]};
    m_ext = irq_ext_i; m_tim = irq_timer_i; m_sw = irq_sw_i;
    if (trap_i) begin
      m_mepc = trap_pc_i & ~32'd3;
      m_mcause = trap_cause_i;
      m_mtval = trap_tval_i;
      m_mpie = m_mie_b;
      m_mie_b = 0;
    end else if (mret_i) begin
      m_mie_b = m_mpie;
      m_mpie = 1;
    end else if (fire) begin
      case (wr_addr_i)
        12'h300: begin m_mie_b = new_v[3]; m_mpie = new_v[7]; end
        12'h304: m_mie_r = new_v & 32'h0000_0888;
        12'h305: m_mtvec = {new_v[31:2], (new_v[1:0] == 2'b01) ? 2'b01 : 2'b00};
        12'h340: m_mscratch = new_v;
        12'h341: m_mepc = new_v & ~32'd3;
        12'h342: m_mcause = new_v;
        12'h343: m_mtval = new_v;
        default: ;
      endcase
    end
  endtask

  // Advance one clock; the model steps with the same inputs and all visible
  // outputs are compared one time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    check("rd_data", rd_data_o, m_rd);
    check("ill_rd", rd_illegal_rd_o, m_ill_rd);
    check("ill_wr", rd_illegal_wr_o, m_ill_wr);
    check("irq_pending", irq_pending_o, m_irq());
    check("trap_vector", trap_vector_o, m_tvec());
    check("mepc", mepc_o, m_mepc);
  endtask

  task automatic do_wr(input logic [11:0] a, input logic [1:0] mode, input logic [31:0] d);
    wr_i = 1; wr_addr_i = a; wr_mode_i = mode; wr_data_i = d;
    tick();
    wr_i = 0; wr_mode_i = 2'b00;
  endtask

  task automatic do_rd(input logic [11:0] a, output logic [31:0] d, output logic ir, output logic iw);
    rd_i = 1; rd_addr_i = a;
    tick();
    d = rd_data_o; ir = rd_illegal_rd_o; iw = rd_illegal_wr_o;
    rd_i = 0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        ill_rd;
    logic        ill_wr;
  } vec_t;

  vec_t        vecs[12];
  logic [11:0] alist[24];

  initial begin
    logic [31:0] d;
    logic        ir, iw;

    resetb_i = 0; clk_en_i = 0; rd_i = 0; wr_i = 0; trap_i = 0; mret_i = 0;
    instret_i = 0; irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
    rd_addr_i = '0; wr_addr_i = '0; wr_mode_i = 2'b00; wr_data_i = '0;
    trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
    model_reset();

    #23;
    check("reset rd_data", rd_data_o, 0);
    check("reset ill_rd", rd_illegal_rd_o, 0);
    check("reset ill_wr", rd_illegal_wr_o, 0);
    check("reset trap_vector", trap_vector_o, 32'h100);
    check("reset mepc", mepc_o, 0);
    check("reset irq_pending", irq_pending_o, 0);
    check("hpl", hpl_o, 2'b11);
    resetb_i = 1;
    clk_en_i = 1;

    // Decode and reset-value table, read straight out of reset.
    vecs = '{
      '{12'h300, 32'h0000_1800, 1'b0, 1'b0}, '{12'h301, 32'h4000_0100, 1'b0, 1'b0},
      '{12'h304, 32'h0, 1'b0, 1'b0},         '{12'h305, 32'h0000_0100, 1'b0, 1'b0},
      '{12'h340, 32'h0, 1'b0, 1'b0},         '{12'h341, 32'h0, 1'b0, 1'b0},
      '{12'h344, 32'h0, 1'b0, 1'b1},         '{12'hF11, 32'h0, 1'b0, 1'b1},
      '{12'hF14, 32'd5, 1'b0, 1'b1},         '{12'h7C0, 32'h0, 1'b1, 1'b1},
      '{12'hC02, 32'h0, 1'b0, 1'b1},         '{12'hB82, 32'h0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      do_rd(vecs[i].addr, d, ir, iw);
      check($sformatf("tbl %h data", vecs[i].addr), d, vecs[i].data);
      check($sformatf("tbl %h ill_rd", vecs[i].addr), ir, vecs[i].ill_rd);
      check($sformatf("tbl %h ill_wr", vecs[i].addr), iw, vecs[i].ill_wr);
    end

    // Vectored interrupt trap: MPIE takes the old MIE, MIE clears.
    do_wr(12'h300, 2'b10, 32'h8);
    do_wr(12'h305, 2'b01, 32'h0000_0201);
    trap_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h0000_2002; trap_tval_i = 32'hDEAD;
    tick();
    trap_i = 0;
    check("seq trap_vector", trap_vector_o, 32'h0000_021C);
    check("seq trap mepc", mepc_o, 32'h0000_2000);
    do_rd(12'h300, d, ir, iw);
    check("seq trap mstatus", d, 32'h0000_1880);

    // mret: MIE <- MPIE (0), MPIE <- 1.
    do_wr(12'h300, 2'b01, 32'h0);
    do_wr(12'h300, 2'b10, 32'h8);
    mret_i = 1;
    tick();
    mret_i = 0;
    do_rd(12'h300, d, ir, iw);
    check("seq mret mstatus", d, 32'h0000_1880);

    // Counter carry across halves; a write beats the same-cycle increment.
    do_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    do_wr(12'hB80, 2'b01, 32'h0);
    tick();
    tick();
    do_rd(12'hB00, d, ir, iw);
    check("seq mcycle", d, 32'd1);
    do_rd(12'hB80, d, ir, iw);
    check("seq mcycleh", d, 32'd1);
    do_wr(12'hB00, 2'b01, 32'h10);
    do_rd(12'hB00, d, ir, iw);
    check("seq mcycle write wins", d, 32'h10);

    // Timer interrupt; with the clock enable low the sample flop holds.
    do_wr(12'h304, 2'b01, 32'h80);
    do_wr(12'h300, 2'b10, 32'h8);
    check("seq irq before", irq_pending_o, 0);
    irq_timer_i = 1;
    tick();
    check("seq irq sampled", irq_pending_o, 1);
    irq_timer_i = 0; clk_en_i = 0;
    tick();
    check("seq irq held", irq_pending_o, 1);
    clk_en_i = 1;
    tick();
    check("seq irq cleared", irq_pending_o, 0);

    // Trap beats a same-cycle CSR write.
    wr_i = 1; wr_mode_i = 2'b01; wr_addr_i = 12'h340; wr_data_i = 32'h1234_5678;
    trap_i = 1; trap_cause_i = 32'd2; trap_pc_i = 32'h0000_4447; trap_tval_i = 32'h0;
    tick();
    wr_i = 0; wr_mode_i = 2'b00; trap_i = 0;
    check("seq trap>wr mepc", mepc_o, 32'h0000_4444);
    do_rd(12'h340, d, ir, iw);
    check("seq trap>wr mscratch", d, 32'h0);
    do_rd(12'h7C0, d, ir, iw);
    check("seq 7C0 ill_rd", ir, 1);
    check("seq 7C0 ill_wr", iw, 1);

    // Reserved mtvec mode stores as direct.
    do_wr(12'h305, 2'b01, 32'h0000_0302);
    do_rd(12'h305, d, ir, iw);
    check("seq mtvec warl", d, 32'h0000_0300);

    // Randomized traffic against the model.
    alist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
              12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h306, 12'hB01};
    for (int i = 0; i < 500; i++) begin
      clk_en_i     = ($urandom_range(0, 7) != 0);
      rd_i         = $urandom_range(0, 1);
      rd_addr_i    = alist[$urandom_range(0, 23)];
      wr_i         = ($urandom_range(0, 2) == 0);
      wr_mode_i    = 2'($urandom_range(0, 3));
      wr_addr_i    = alist[$urandom_range(0, 23)];
      wr_data_i    = $urandom;
      trap_i       = ($urandom_range(0, 15) == 0);
      trap_cause_i = $urandom & 32'h8000_001F;
      trap_pc_i    = $urandom;
      trap_tval_i  = $urandom;
      mret_i       = ($urandom_range(0, 15) == 0);
      instret_i    = $urandom_range(0, 1);
      irq_ext_i    = ($urandom_range(0, 3) == 0);
      irq_timer_i  = ($urandom_range(0, 3) == 0);
      irq_sw_i     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
